// File: rtl/jogador_pkg.sv
// Shared types, constants and helpers for the automatic player.
// The optional wrong-play feature is enabled with the JOGADOR_ERRO_EN macro.
package jogador_pkg;

  localparam int IDX_W = 4;
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    INICIA,
    ESPERA_INI,
    JOGA,
    SOLTA,
    AVALIA,
    FIM
  } estado_t;

  // One-hot play for index i: 0001 rotated left by (i mod 4).
  function automatic logic [3:0] seq(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  function automatic logic [3:0] rotl1(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  // Phase length n becomes a load value of n-1, so the expired cycle is the last one.
  function automatic logic [CNT_W-1:0] fase_len(input int n);
    return (n <= 1) ? {CNT_W{1'b0}} : CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/jogador_automatico_if.sv
// Control and game-side signals of the automatic player, grouped as one bundle.
// master = the player, slave = whoever drives start and the game flags.
interface jogador_automatico_if;
  import jogador_pkg::*;

  logic             start;
  logic             pronto;
  logic             acertou;
  logic             errou;
  logic             iniciar;
  logic [3:0]       chaves;
  logic             busy;
  logic             done;
  logic             resultado_ok;
  logic [IDX_W-1:0] jogada_idx;

  modport master (
    input  start, pronto, acertou, errou,
    output iniciar, chaves, busy, done, resultado_ok, jogada_idx
  );

  modport slave (
    output start, pronto, acertou, errou,
    input  iniciar, chaves, busy, done, resultado_ok, jogada_idx
  );

endinterface

// File: rtl/jogador_automatico_contador_fase.sv
// Down-counting phase timer: load sets the phase length, expirado flags its last cycle.
module contador_fase
  import jogador_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expirado
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expirado = (cnt_q == '0);

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player: starts a game, drives a fixed one-hot play sequence and reports the result.
// Define JOGADOR_ERRO_EN to inject one deliberately wrong, shortened play at ERRO_IDX.
module jogador_automatico
  import jogador_pkg::*;
#(
  parameter int INIT_CYCLES = 5,
  parameter int HOLD_CYCLES = 10,
  parameter int GAP_CYCLES  = 10,
  parameter int NUM_JOGADAS = 16
`ifdef JOGADOR_ERRO_EN
  ,
  parameter int ERRO_IDX    = 3
`endif
) (
  input  logic                clock,
  input  logic                reset,
  jogador_automatico_if.master bus
);

  localparam logic [IDX_W-1:0] ULTIMA_IDX = IDX_W'(NUM_JOGADAS - 1);

  estado_t          state_q, state_d;
  logic             iniciar_q, iniciar_d;
  logic [3:0]       chaves_q, chaves_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             resultado_ok_q, resultado_ok_d;
  logic [IDX_W-1:0] jogada_idx_q, jogada_idx_d;

  logic [IDX_W-1:0] idx_play;
  logic [3:0]       play_valor;
  logic [CNT_W-1:0] play_len;
  logic [CNT_W-1:0] fase_load_val;
  logic             fase_load;
  logic             fase_en;
  logic             fase_expirada;

  // From AVALIA the next play is the one after the current index.
  assign idx_play = (state_q == AVALIA) ? (jogada_idx_q + IDX_W'(1)) : jogada_idx_q;

`ifdef JOGADOR_ERRO_EN
  logic erro_play;
  assign erro_play  = (idx_play == IDX_W'(ERRO_IDX));
  assign play_valor = erro_play ? rotl1(seq(idx_play[1:0])) : seq(idx_play[1:0]);
  assign play_len   = erro_play ? fase_len(HOLD_CYCLES / 2) : fase_len(HOLD_CYCLES);
`else
  assign play_valor = seq(idx_play[1:0]);
  assign play_len   = fase_len(HOLD_CYCLES);
`endif

  always_comb begin
    state_d        = state_q;
    iniciar_d      = 1'b0;
    chaves_d       = 4'b0000;
    busy_d         = 1'b1;
    done_d         = 1'b0;
    resultado_ok_d = resultado_ok_q;
    jogada_idx_d   = jogada_idx_q;
    fase_load_val  = '0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          state_d        = INICIA;
          busy_d         = 1'b1;
          iniciar_d      = 1'b1;
          jogada_idx_d   = '0;
          resultado_ok_d = 1'b0;
          fase_load_val  = fase_len(INIT_CYCLES);
        end
      end

      INICIA: begin
        if (fase_expirada) begin
          state_d       = ESPERA_INI;
          fase_load_val = fase_len(GAP_CYCLES);
        end else begin
          iniciar_d = 1'b1;
        end
      end

      ESPERA_INI: begin
        if (fase_expirada) begin
          state_d       = JOGA;
          chaves_d      = play_valor;
          fase_load_val = play_len;
        end
      end

      JOGA: begin
        if (fase_expirada) begin
          state_d       = SOLTA;
          fase_load_val = fase_len(GAP_CYCLES);
        end else begin
          chaves_d = play_valor;
        end
      end

      SOLTA: begin
        if (fase_expirada) begin
          state_d = AVALIA;
        end
      end

      // Game flags are only looked at here, never mid-phase.
      AVALIA: begin
        if (bus.errou) begin
          state_d        = FIM;
          done_d         = 1'b1;
          resultado_ok_d = 1'b0;
        end else if (bus.pronto && bus.acertou) begin
          state_d        = FIM;
          done_d         = 1'b1;
          resultado_ok_d = 1'b1;
        end else if (jogada_idx_q == ULTIMA_IDX) begin
          state_d        = FIM;
          done_d         = 1'b1;
          resultado_ok_d = 1'b0;
        end else begin
          state_d       = JOGA;
          jogada_idx_d  = idx_play;
          chaves_d      = play_valor;
          fase_load_val = play_len;
        end
      end

      FIM: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      iniciar_q      <= 1'b0;
      chaves_q       <= 4'b0000;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      resultado_ok_q <= 1'b0;
      jogada_idx_q   <= '0;
    end else begin
      state_q        <= state_d;
      iniciar_q      <= iniciar_d;
      chaves_q       <= chaves_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      resultado_ok_q <= resultado_ok_d;
      jogada_idx_q   <= jogada_idx_d;
    end
  end

  // Every state change reloads the timer, so each phase starts from a fresh count.
  assign fase_load = (state_d != state_q);
  assign fase_en   = (state_q != IDLE);

  contador_fase u_contador_fase (
    .clock    (clock),
    .reset    (reset),
    .load     (fase_load),
    .load_val (fase_load_val),
    .en       (fase_en),
    .expirado (fase_expirada)
  );

  assign bus.iniciar      = iniciar_q;
  assign bus.chaves       = chaves_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.resultado_ok = resultado_ok_q;
  assign bus.jogada_idx   = jogada_idx_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Scoreboard bench for jogador_automatico: stimulus queues expected events, a monitor matches them.
// Build with JOGADOR_ERRO_EN defined to also exercise the wrong-play feature.
module tb_jogador_automatico;
  import jogador_pkg::*;

  localparam int INIT_C = 5;
  localparam int HOLD_C = 10;
  localparam int GAP_C  = 10;

  typedef enum int {EV_INI, EV_GAP, EV_PLAY, EV_DONE, EV_RESTART} ev_kind_t;
  typedef enum int {M_NEVER, M_WIN, M_BOTH, M_ERR} modo_t;

  typedef struct {
    ev_kind_t kind;
    int       data;
    int       len;
    string    name;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  logic clock   = 1'b0;
  logic reset   = 1'b1;
  logic start_v = 1'b0;
  logic sel     = 1'b0;
  logic g_pronto  = 1'b0;
  logic g_acertou = 1'b0;
  logic g_errou   = 1'b0;
  modo_t modo      = M_NEVER;
  int    win_after = 0;

  jogador_automatico_if ifa ();
  jogador_automatico_if ifb ();

  assign ifa.start   = start_v & ~sel;
  assign ifb.start   = start_v & sel;
  assign ifa.pronto  = g_pronto;
  assign ifb.pronto  = g_pronto;
  assign ifa.acertou = g_acertou;
  assign ifb.acertou = g_acertou;
  assign ifa.errou   = g_errou;
  assign ifb.errou   = g_errou;

  jogador_automatico dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (ifa)
  );

  jogador_automatico #(.NUM_JOGADAS(2)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (ifb)
  );

  always #5 clock = ~clock;

  logic       m_ini, m_busy, m_done, m_ok;
  logic [3:0] m_chaves, m_idx;
  assign m_ini    = sel ? ifb.iniciar      : ifa.iniciar;
  assign m_busy   = sel ? ifb.busy         : ifa.busy;
  assign m_done   = sel ? ifb.done         : ifa.done;
  assign m_ok     = sel ? ifb.resultado_ok : ifa.resultado_ok;
  assign m_chaves = sel ? ifb.chaves       : ifa.chaves;
  assign m_idx    = sel ? ifb.jogada_idx   : ifa.jogada_idx;

  function automatic int tb_seq(input int i);
    case (i % 4)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int exp_val(input int i);
`ifdef JOGADOR_ERRO_EN
    if (i == 3) return 1;
`endif
    return tb_seq(i);
  endfunction

  function automatic int exp_len(input int i);
`ifdef JOGADOR_ERRO_EN
    if (i == 3) return HOLD_C / 2;
`endif
    return HOLD_C;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic push(input ev_kind_t k, input int d, input int l, input string n);
    ev_t e;
    e.kind = k;
    e.data = d;
    e.len  = l;
    e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic pushGame(input string tag, input int n_plays, input int ok, input int last_idx);
    push(EV_INI, 0, INIT_C, {tag, "_iniciar"});
    push(EV_GAP, 0, GAP_C, {tag, "_gap"});
    for (int i = 0; i < n_plays; i++) begin
      push(EV_PLAY, exp_val(i), exp_len(i), $sformatf("%s_play%0d", tag, i));
    end
    push(EV_DONE, ok * 16 + last_idx, 1, {tag, "_done"});
  endtask

  task automatic report(input ev_kind_t k, input int d, input int l);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_event: got kind=%0d data=%0d len=%0d, want none", k, d, l);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.data != d || e.len != l) begin
        errors++;
        $display("[TB] FAIL %s: got kind=%0d data=%0d len=%0d, want kind=%0d data=%0d len=%0d",
                 e.name, k, d, l, e.kind, e.data, e.len);
      end
    end
  endtask

  task automatic applyStimulus(input modo_t m, input int w);
    modo      = m;
    win_after = w;
    @(negedge clock);
    start_v = 1'b1;
    @(negedge clock);
    start_v = 1'b0;
  endtask

  task automatic waitDone(input string name, input int bound);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!m_done && n < bound);
    if (!m_done) checkOutput({name, "_timeout"}, int'(m_done), 1);
  endtask

  task automatic waitChaves(input string name, input logic [3:0] v, input int bound);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (m_chaves != v && n < bound);
    if (m_chaves != v) checkOutput({name, "_timeout"}, int'(m_chaves), int'(v));
  endtask

  task automatic waitIni(input string name, input int bound);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!m_ini && n < bound);
    if (!m_ini) checkOutput({name, "_timeout"}, int'(m_ini), 1);
  endtask

  // Monitor: turns output activity into events and matches them against the queue.
  int         ini_len = 0, gap_len = 0, play_len = 0, done_len = 0, done_age = 0, done_data = 0;
  logic [3:0] play_val = 4'b0000;
  bit         gap_on = 1'b0;
  logic       p_ini = 1'b0, p_done = 1'b0;
  logic [3:0] p_chaves = 4'b0000;

  initial begin
    forever begin
      @(negedge clock);
      if (m_done && !p_done) begin
        done_len  = 0;
        done_data = int'(m_ok) * 16 + int'(m_idx);
      end
      if (m_done) done_len++;
      if (!m_done && p_done) report(EV_DONE, done_data, done_len);
      if (m_done) done_age = 0;
      else done_age++;

      if (m_ini && !p_ini) begin
        if (exp_q.size() > 0 && exp_q[0].kind == EV_RESTART) report(EV_RESTART, 0, done_age);
        ini_len = 0;
      end
      if (m_ini) ini_len++;
      if (!m_ini && p_ini) begin
        report(EV_INI, 0, ini_len);
        gap_on  = 1'b1;
        gap_len = 0;
      end
      if (gap_on) begin
        if (m_chaves == 4'b0000) gap_len++;
        else begin
          report(EV_GAP, 0, gap_len);
          gap_on = 1'b0;
        end
      end

      if (m_chaves != p_chaves) begin
        if (p_chaves != 4'b0000) report(EV_PLAY, int'(play_val), play_len);
        if (m_chaves != 4'b0000) begin
          play_val = m_chaves;
          play_len = 0;
        end
      end
      if (m_chaves != 4'b0000) play_len++;

      p_ini    = m_ini;
      p_done   = m_done;
      p_chaves = m_chaves;
    end
  end

  // Game model: raises result flags once the configured play shows up on chaves.
  int         mod_cnt = 0;
  logic [3:0] mod_prev = 4'b0000;

  initial begin
    forever begin
      @(negedge clock);
      if (m_ini) begin
        g_pronto  = 1'b0;
        g_acertou = 1'b0;
        g_errou   = 1'b0;
        mod_cnt   = 0;
      end
      if (m_chaves != 4'b0000 && mod_prev == 4'b0000) begin
        mod_cnt++;
        case (modo)
          M_WIN: if (mod_cnt == win_after) begin
            g_pronto  = 1'b1;
            g_acertou = 1'b1;
          end
          M_BOTH: if (mod_cnt == win_after) begin
            g_pronto  = 1'b1;
            g_acertou = 1'b1;
            g_errou   = 1'b1;
          end
          M_ERR: if (int'(m_chaves) != tb_seq(mod_cnt - 1)) g_errou = 1'b1;
          default: ;
        endcase
      end
      mod_prev = m_chaves;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of run, want summary before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;

    repeat (3) @(negedge clock);
    checkOutput("rst_iniciar", int'(ifa.iniciar), 0);
    checkOutput("rst_chaves", int'(ifa.chaves), 0);
    checkOutput("rst_busy", int'(ifa.busy), 0);
    checkOutput("rst_done", int'(ifa.done), 0);
    checkOutput("rst_resultado_ok", int'(ifa.resultado_ok), 0);
    checkOutput("rst_jogada_idx", int'(ifa.jogada_idx), 0);
    checkOutput("rst_busy_b", int'(ifb.busy), 0);
    reset = 1'b0;

    $display("[TB] win after four plays");
    pushGame("win4", 4, 1, 3);
    applyStimulus(M_WIN, 4);
    waitDone("win4", 400);
    repeat (3) @(negedge clock);
    checkOutput("win4_idle_busy", int'(m_busy), 0);
    checkOutput("win4_hold_ok", int'(m_ok), 1);
    checkOutput("win4_hold_idx", int'(m_idx), 3);

    $display("[TB] start pulse during JOGA");
    pushGame("ign", 2, 1, 1);
    applyStimulus(M_WIN, 2);
    waitChaves("ign_play", 4'b0001, 100);
    checkOutput("ign_ok_cleared", int'(m_ok), 0);
    repeat (3) @(negedge clock);
    start_v = 1'b1;
    @(negedge clock);
    start_v = 1'b0;
    waitDone("ign", 400);
    repeat (3) @(negedge clock);
    checkOutput("ign_no_restart", int'(m_busy), 0);

    $display("[TB] errou has priority over pronto/acertou");
    pushGame("prio", 2, 0, 1);
    applyStimulus(M_BOTH, 2);
    waitDone("prio", 400);
    repeat (3) @(negedge clock);

    $display("[TB] start held high");
    pushGame("held1", 1, 1, 0);
    push(EV_RESTART, 0, 2, "held_restart_latency");
    pushGame("held2", 1, 1, 0);
    modo      = M_WIN;
    win_after = 1;
    @(negedge clock);
    start_v = 1'b1;
    waitDone("held1", 400);
    waitIni("held_restart", 10);
    start_v = 1'b0;
    waitDone("held2", 400);
    repeat (3) @(negedge clock);

    $display("[TB] reset during play 2");
    push(EV_INI, 0, INIT_C, "rst_game_iniciar");
    push(EV_GAP, 0, GAP_C, "rst_game_gap");
    push(EV_PLAY, 1, HOLD_C, "rst_game_play0");
    push(EV_PLAY, 2, 4, "rst_game_play1_cut");
    applyStimulus(M_NEVER, 0);
    waitChaves("rst_game_play1", 4'b0010, 200);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midrst_chaves", int'(ifa.chaves), 0);
    checkOutput("midrst_busy", int'(ifa.busy), 0);
    checkOutput("midrst_idx", int'(ifa.jogada_idx), 0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (ifa.chaves != 4'b0000 || ifa.busy) seen++;
    end
    checkOutput("midrst_no_more_plays", seen, 0);

    $display("[TB] NUM_JOGADAS=2 without result");
    sel = 1'b1;
    pushGame("lim2", 2, 0, 1);
    applyStimulus(M_NEVER, 0);
    waitDone("lim2", 400);
    repeat (3) @(negedge clock);
    checkOutput("lim2_idle_busy", int'(m_busy), 0);
    sel = 1'b0;
    repeat (2) @(negedge clock);

`ifdef JOGADOR_ERRO_EN
    $display("[TB] wrong play at index 3");
    pushGame("erro", 4, 0, 3);
    applyStimulus(M_ERR, 0);
    waitDone("erro", 400);
    repeat (3) @(negedge clock);
`endif

    checkOutput("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jogador_automatico.md
JOGADOR_AUTOMATICO -- requirements
Module: jogador_automatico

Interface
REQ-001 Parameter INIT_CYCLES, default 5: clock cycles iniciar is held high.
REQ-002 Parameter HOLD_CYCLES, default 10: clock cycles each play is held on chaves.
REQ-003 Parameter GAP_CYCLES, default 10: idle cycles after iniciar and after each play.
REQ-004 Parameter NUM_JOGADAS, default 16, range 1..16: maximum plays attempted per game.
REQ-005 clock  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request to play one game; sampled only in IDLE.
REQ-008 pronto  input  1  game-finished flag from the game circuit.
REQ-009 acertou  input  1  game-won flag from the game circuit.
REQ-010 errou  input  1  game-lost flag from the game circuit.
REQ-011 iniciar  output  1  start strobe to the game circuit.
REQ-012 chaves  output  4  one-hot play to the game circuit; 4'b0000 when not playing.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on entry to FIM.
REQ-015 resultado_ok  output  1  game outcome, valid from done until the next start.
REQ-016 jogada_idx  output  4  index of the current or last play.

Function
REQ-017 The block SHALL have these FSM states: IDLE, INICIA, ESPERA_INI, JOGA, SOLTA, AVALIA, FIM.
REQ-018 IDLE: start=1 SHALL move to INICIA, clear jogada_idx to 0 and clear resultado_ok.
REQ-019 INICIA SHALL drive iniciar=1 for exactly INIT_CYCLES cycles, then go to ESPERA_INI.
REQ-020 ESPERA_INI SHALL last GAP_CYCLES cycles with iniciar=0 and chaves=0, then go to JOGA.
REQ-021 JOGA SHALL drive chaves=seq(jogada_idx) for exactly HOLD_CYCLES cycles, then go to SOLTA.
REQ-022 seq(i) SHALL be 4'b0001 rotated left by (i mod 4): 0001, 0010, 0100, 1000, 0001, and so on.
REQ-023 SOLTA SHALL drive chaves=0 for GAP_CYCLES cycles, then go to AVALIA.
REQ-024 AVALIA SHALL take one cycle and resolve in priority order, first match wins:
  - errou=1 -> FIM, resultado_ok=0.
  - pronto=1 and acertou=1 -> FIM, resultado_ok=1.
  - jogada_idx=NUM_JOGADAS-1 -> FIM, resultado_ok=0.
  - otherwise -> increment jogada_idx, go to JOGA.
REQ-025 errou or pronto asserting during JOGA or SOLTA SHALL NOT shorten the current phase; it is acted on only in AVALIA.
REQ-026 FIM SHALL pulse done for one cycle, hold resultado_ok and jogada_idx, then return to IDLE.
REQ-027 start=1 outside IDLE SHALL be ignored; start held high through FIM SHALL begin a new game one cycle after return to IDLE.
REQ-028 The phase counter SHALL reload on every state entry, so each phase length is exact regardless of prior state.
REQ-029 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-030 Reset SHALL force state=IDLE and set iniciar=0, chaves=0, busy=0, done=0, resultado_ok=0, jogada_idx=0 on the next rising edge.
REQ-031 Reset asserted mid-game, including mid-JOGA, SHALL drop chaves to 0 on that edge, with no partial play completed afterwards.

Configuration
REQ-032 Macro JOGADOR_ERRO_EN, when defined, SHALL add parameter ERRO_IDX (default 3).
REQ-033 With JOGADOR_ERRO_EN defined, the play at jogada_idx=ERRO_IDX SHALL be seq(ERRO_IDX) rotated left by one position (for example 0001 instead of 1000), and that play SHALL be held for HOLD_CYCLES/2 cycles.
REQ-034 Without JOGADOR_ERRO_EN, no ERRO_IDX logic SHALL exist, and every play SHALL be the correct value.

Structure
REQ-035 Package jogador_pkg SHALL hold the state enumeration, the seq() function and the width constant for jogada_idx (4).
REQ-036 The phase timer SHALL be a sub-module named contador_fase, with load value, load strobe, enable and an expired flag.

Verification
REQ-037 reset, then start pulse with defaults -> iniciar high exactly 5 cycles, chaves=0 for the next 10 cycles, first play 0001 held exactly 10 cycles.
REQ-038 Game model asserts pronto=1 and acertou=1 after play 4 -> chaves sequence is 0001, 0010, 0100, 1000; done pulses once; resultado_ok=1; jogada_idx=3.
REQ-039 JOGADOR_ERRO_EN with ERRO_IDX=3, and the model asserts errou=1 on a wrong play -> 4th play is 0001 held 5 cycles, then done with resultado_ok=0 and jogada_idx=3.
REQ-040 Reset asserted on the 4th cycle of play 2 -> chaves=0 and busy=0 on the next edge, and no further plays are driven.
REQ-041 start pulsed during JOGA -> ignored, with timing and sequence unchanged; start held high continuously -> a new game's iniciar begins one cycle after done.
REQ-042 NUM_JOGADAS=2 and the model never flags a result -> exactly 2 plays are driven, then done with resultado_ok=0.
